// File: rtl/clkdiv_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

   // Largest supported channel count and the index width able to address it.
   localparam int MAX_CH   = 16;
   localparam int MAX_CH_W = $clog2(MAX_CH);

   // Channel index wide enough for any legal cfg_ch, so decode can zero-extend into it.
   typedef logic [MAX_CH_W-1:0] ch_idx_t;

   // Channel-select width for a given channel count: max(1, clog2(n)).
   function automatic int ch_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Divisors below 2 cannot form a high and a low phase; treat them as 2.
   function automatic logic [31:0] clamp_div(input logic [31:0] div);
      return (div < 32'd2) ? 32'd2 : div;
   endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/pending divisor and registered outputs.
// A new divisor waits in div_pend and takes over only at a period boundary
// (wrap) or while the channel is idle, so a running period is never cut short.
// Optional macro CLKDIV_PHASE_SYNC_EN adds the sync input (phase restart).
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int CNT_W       = 31,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
`ifdef CLKDIV_PHASE_SYNC_EN
   input  logic             sync,
`endif
   output logic             clock_out,
   output logic             tick,
   output logic             pend_v
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_act_q, div_act_d;
   logic [CNT_W-1:0] div_pend_q, div_pend_d;
   logic             pend_v_q, pend_v_d;
   logic             clock_out_q, clock_out_d;
   logic             tick_q, tick_d;
   logic             wrap;
   logic             restart;

   // Next-state: count through the period, restart when idle, swap divisor at boundaries.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
      wrap        = (cnt_q == div_act_q - CNT_W'(1));
`ifdef CLKDIV_PHASE_SYNC_EN
      restart     = !en || sync;
`else
      restart     = !en;
`endif
      cnt_d       = (restart || wrap) ? '0 : cnt_q + CNT_W'(1);
      clock_out_d = !restart && (cnt_q < (div_act_q >> 1));
      tick_d      = !restart && wrap;
      div_act_d   = div_act_q;
      div_pend_d  = div_pend_q;
      pend_v_d    = pend_v_q;
      // A write is only accepted while nothing is pending, so it never collides with the swap.
      if (pend_v_q && (restart || wrap)) begin
         div_act_d = div_pend_q;
         pend_v_d  = 1'b0;
      end
      if (wr) begin
         div_pend_d = CNT_W'(clamp_div(32'(wr_div)));
         pend_v_d   = 1'b1;
      end
   end

   // State register; reset brings up an idle channel running at DEFAULT_DIV.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         div_act_q   <= CNT_W'(DEFAULT_DIV);
         div_pend_q  <= CNT_W'(DEFAULT_DIV);
         pend_v_q    <= 1'b0;
         clock_out_q <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         cnt_q       <= cnt_d;
         div_act_q   <= div_act_d;
         div_pend_q  <= div_pend_d;
         pend_v_q    <= pend_v_d;
         clock_out_q <= clock_out_d;
         tick_q      <= tick_d;
      end
   end

   assign clock_out = clock_out_q;
   assign tick      = tick_q;
   assign pend_v    = pend_v_q;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH-channel clock divider with a valid/ready divisor config port.
// Top level: config decode, cfg_ready mux, cfg_err pulse, channel array.
// Optional macro CLKDIV_PHASE_SYNC_EN adds sync_in, which restarts all
// channels phase-aligned.
module clock_divider_multi
   import clkdiv_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 31,
   parameter int DEFAULT_DIV = 2,
   parameter int CH_W        = ch_w(NUM_CH)
) (
   input  logic              clock_in,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] enable,
   input  logic              cfg_valid,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic              cfg_ready,
   output logic              cfg_err,
`ifdef CLKDIV_PHASE_SYNC_EN
   input  logic              sync_in,
`endif
   output logic [NUM_CH-1:0] clock_out,
   output logic [NUM_CH-1:0] tick
);

   logic [NUM_CH-1:0] pend_v;
   logic [NUM_CH-1:0] wr;
   ch_idx_t           ch_ext;
   logic              ch_hit;
   logic              ch_busy;
   logic              accept;
   logic              cfg_err_q, cfg_err_d;

   // Decode the target channel; out-of-range targets are always ready and only raise cfg_err.
   always_comb begin
      ch_ext  = ch_idx_t'(cfg_ch);
      ch_hit  = 1'b0;
      ch_busy = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_ext == ch_idx_t'(i)) begin
            ch_hit  = 1'b1;
            ch_busy = pend_v[i];
         end
      end
      cfg_ready = !ch_busy;
      accept    = cfg_valid && cfg_ready;
      wr        = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr[i] = accept && (ch_ext == ch_idx_t'(i));
      end
      cfg_err_d = accept && !ch_hit;
   end

   // One-cycle error pulse for a dropped out-of-range request.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg_err_d;
      end
   end

   assign cfg_err = cfg_err_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clkdiv_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk       (clock_in),
         .rst_n     (reset_n),
         .en        (enable[g]),
         .wr        (wr[g]),
         .wr_div    (cfg_div),
`ifdef CLKDIV_PHASE_SYNC_EN
         .sync      (sync_in),
`endif
         .clock_out (clock_out[g]),
         .tick      (tick[g]),
         .pend_v    (pend_v[g])
      );
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: directed scenarios plus random
// traffic, all compared against a period-level reference model.
module tb_clock_divider_multi;

   localparam int NUM_CH      = 5;
   localparam int CNT_W       = 31;
   localparam int DEFAULT_DIV = 2;
   localparam int CH_W        = 3;

   logic              clock_in = 1'b0;
   logic              reset_n  = 1'b0;
   logic [NUM_CH-1:0] enable   = '0;
   logic              cfg_valid = 1'b0;
   logic [CH_W-1:0]   cfg_ch   = '0;
   logic [CNT_W-1:0]  cfg_div  = '0;
   logic              sync_in  = 1'b0;
   logic              cfg_ready;
   logic              cfg_err;
   logic [NUM_CH-1:0] clock_out;
   logic [NUM_CH-1:0] tick;

   always #5 clock_in = ~clock_in;

   clock_divider_multi #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .enable    (enable),
      .cfg_valid (cfg_valid),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
`ifdef CLKDIV_PHASE_SYNC_EN
      .sync_in   (sync_in),
`endif
      .clock_out (clock_out),
      .tick      (tick)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: position inside the current period, active divisor,
   // and at most one queued divisor per channel.
   int m_pos  [NUM_CH];
   int m_div  [NUM_CH];
   int m_pend [NUM_CH];
   bit m_pv   [NUM_CH];
   bit m_err;

   function automatic void model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_pos[i] = 0; m_div[i] = DEFAULT_DIV; m_pend[i] = 0; m_pv[i] = 0;
      end
      m_err = 0;
   endfunction

   function automatic bit model_ready(input int ch);
      return (ch >= NUM_CH) ? 1'b1 : !m_pv[ch];
   endfunction

   task automatic drive(input logic [NUM_CH-1:0] en, input bit valid, input int ch, input int div);
      enable    = en;
      cfg_valid = valid;
      cfg_ch    = CH_W'(ch);
      cfg_div   = CNT_W'(div);
   endtask

   // One clock: check cfg_ready, advance the model over the edge, check registered outputs.
   task automatic cycle();
      logic [NUM_CH-1:0] exp_out, exp_tick;
      bit acc, period_done, restart;
      int ch;
      #1;
      ch  = int'(cfg_ch);
      check("cfg_ready", 32'(cfg_ready), 32'(model_ready(ch)));
      acc = cfg_valid && model_ready(ch);
      for (int i = 0; i < NUM_CH; i++) begin
         restart = !enable[i] || (sync_in === 1'b1);
         if (restart) begin
            exp_out[i] = 1'b0; exp_tick[i] = 1'b0;
            m_pos[i] = 0; period_done = 1;
         end else begin
            exp_out[i]  = (m_pos[i] < m_div[i] / 2);
            exp_tick[i] = (m_pos[i] == m_div[i] - 1);
            period_done = exp_tick[i];
            m_pos[i]    = period_done ? 0 : m_pos[i] + 1;
         end
         if (period_done && m_pv[i]) begin
            m_div[i] = m_pend[i]; m_pv[i] = 0;
         end
         if (acc && ch == i) begin
            m_pend[i] = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
            m_pv[i]   = 1;
         end
      end
      m_err = acc && (ch >= NUM_CH);
      @(posedge clock_in);
      #1;
      check("clock_out", 32'(clock_out), 32'(exp_out));
      check("tick", 32'(tick), 32'(exp_tick));
      check("cfg_err", 32'(cfg_err), 32'(m_err));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Advance until channel ch sits at model position pos, bounded by a cycle budget.
   task automatic seek(input int ch, input int pos, input string tag);
      int k;
      for (k = 0; k < 40 && m_pos[ch] != pos; k++) cycle();
      check(tag, 32'(m_pos[ch] == pos), 32'd1);
   endtask

   logic [3:0] pat_out  = 4'b0101;
   logic [3:0] pat_tick = 4'b1010;

   initial begin
      model_reset();
      // Reset state, with reset held across edges.
      repeat (2) @(posedge clock_in);
      #1;
      check("rst_clock_out", 32'(clock_out), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_cfg_err", 32'(cfg_err), 32'd0);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      reset_n = 1'b1;

      // Default divisor 2 on channel 0: 1,0,1,0 with tick on every second cycle.
      drive(5'b00001, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("div2_out", 32'(clock_out[0]), 32'(pat_out[k]));
         check("div2_tick", 32'(tick[0]), 32'(pat_tick[k]));
      end

      // Divisor 5 on running channel 1; request held so ready low is seen.
      drive(5'b00011, 0, 0, 0);
      run(1);
      drive(5'b00011, 1, 1, 5);
      run(3);
      drive(5'b00011, 0, 1, 5);
      run(15);

      // Divisor 0 clamps to 2; out-of-range channels raise cfg_err only.
      drive(5'b00111, 1, 2, 0);
      run(1);
      drive(5'b00111, 0, 2, 0);
      run(6);
      drive(5'b00111, 1, 5, 9);
      run(1);
      drive(5'b00111, 1, 7, 3);
      run(1);
      drive(5'b00111, 0, 0, 0);
      run(4);

      // Accept divisor 4 on channel 0 exactly on its wrap cycle.
      seek(0, 1, "seek_wrap");
      drive(5'b00111, 1, 0, 4);
      run(1);
      drive(5'b00111, 0, 0, 0);
      run(12);

      // Drop enable on channel 1 while its output is high, then re-enable.
      seek(1, 1, "seek_high");
      check("pre_drop_high", 32'(clock_out[1]), 32'd1);
      drive(5'b00101, 0, 0, 0);
      run(1);
      check("en_drop", 32'(clock_out[1]), 32'd0);
      run(2);
      drive(5'b00111, 0, 0, 0);
      run(1);
      check("re_enable", 32'(clock_out[1]), 32'd1);
      run(6);

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         logic [NUM_CH-1:0] en;
         for (int i = 0; i < NUM_CH; i++) en[i] = ($urandom_range(0, 7) != 0);
         drive(en, ($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom_range(0, 9));
         cycle();
      end

`ifdef CLKDIV_PHASE_SYNC_EN
      // Channels at 3 and 6 restarted together by sync_in.
      drive(5'b00000, 1, 0, 3);
      run(2);
      drive(5'b00000, 1, 3, 6);
      run(2);
      drive(5'b01001, 0, 0, 0);
      run(7);
      sync_in = 1'b1;
      run(1);
      sync_in = 1'b0;
      check("sync_low0", 32'(clock_out[0]), 32'd0);
      check("sync_low3", 32'(clock_out[3]), 32'd0);
      for (int k = 0; k < 12; k++) begin
         cycle();
         if (k % 6 == 0) begin
            check("sync_rise0", 32'(clock_out[0]), 32'd1);
            check("sync_rise3", 32'(clock_out[3]), 32'd1);
         end
      end
`endif

      drive(5'b00000, 0, 0, 0);
      run(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
